// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage access into a single data-memory bus
// transaction (or an immediate misalign report) and returns a one-cycle completion.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        accept;
    logic        req_misaligned;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b1;
        endcase
    end

    // Right-align the addressed lane, then extend according to the access size.
    always_comb begin
        lane      = mem_rdata >> {addr_q[1:0], 3'b000};
        load_data = lane;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'b01:   load_data = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= 8'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = 32'h0;
                    misalign_d = req_misaligned;
                    timeout_d  = 1'b0;
                    cnt_d      = 8'd1;
                    state_d    = req_misaligned ? RESP : BUS;
                end
            end
            BUS: begin
                // A ready on the final allowed cycle still counts as completion.
                if (mem_ready) begin
                    rdata_d = we_q ? 32'h0 : load_data;
                    state_d = RESP;
                end else if (cnt_q >= TIMEOUT_LIM) begin
                    rdata_d   = 32'h0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = (state_q == IDLE) && !rst;
        mem_valid    = (state_q == BUS);
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        mem_wstrb    = 4'b0000;
        mem_wdata    = 32'h0;
        rsp_valid    = (state_q == RESP);
        rsp_rdata    = 32'h0;
        rsp_misalign = 1'b0;
        rsp_timeout  = 1'b0;
        if (state_q == BUS) begin
            mem_we   = we_q;
            mem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
                case (size_q)
                    2'b00: begin
                        mem_wstrb = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_wstrb = 4'b0011 << addr_q[1:0];
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_wstrb = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
        if (state_q == RESP) begin
            rsp_rdata    = rdata_q;
            rsp_misalign = misalign_q;
            rsp_timeout  = timeout_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: driver issues accesses and plays
// memory, monitor compares every bus cycle and every completion against the model.
module tb_load_store_unit;

    localparam int TO     = 4;
    localparam int N_RAND = 150;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_misalign, rsp_timeout;
    logic [31:0] rsp_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        int          w;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        tmo;
        int          at;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    rsp_t        exp_q[$];
    txn_t        txns[$];
    logic        exp_mem_valid;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Reference model: byte-count arithmetic, independent of the RTL encoding.
    function automatic bit model_mis(input txn_t t);
        int n;
        if (t.size == 2'd3) return 1'b1;
        n = 1 << t.size;
        return (int'(t.addr[1:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input txn_t t);
        int n;
        if (!t.we) return 4'b0000;
        n = 1 << t.size;
        return 4'(((1 << n) - 1) << int'(t.addr[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input txn_t t);
        logic [31:0] r;
        int n;
        r = 32'h0;
        if (!t.we) return r;
        n = 1 << t.size;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = t.wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input txn_t t);
        logic [31:0] v, mask;
        int n;
        n = 1 << t.size;
        v = t.data >> (8 * int'(t.addr[1:0]));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (!t.uns && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.size  = 2'($urandom_range(0, 3));
        t.uns   = 1'($urandom_range(0, 1));
        t.addr  = $urandom;
        if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
        t.wdata = $urandom;
        t.data  = $urandom;
        t.w     = $urandom_range(0, TO + 1);
        return t;
    endfunction

    task automatic present(input txn_t t);
        req_valid    = 1'b1;
        req_we       = t.we;
        req_size     = t.size;
        req_unsigned = t.uns;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
    endtask

    task automatic scramble();
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic wait_accept(output int a, output bit ok);
        logic r;
        ok = 1'b0;
        a  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            if (r) begin
                a  = cyc;
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_wait actual=no_accept required=accept_within_30 cyc=%0d", cyc);
    endtask

    task automatic bus_phase(input txn_t t);
        if (model_mis(t)) return;
        exp_we        = t.we;
        exp_addr      = t.addr & ~32'h3;
        exp_wstrb     = model_strb(t);
        exp_wdata     = model_wdata(t);
        exp_mem_valid = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            mem_ready = (k == t.w + 1);
            mem_rdata = (k == t.w + 1) ? t.data : $urandom;
            @(posedge clk);
            #1;
            if (k == t.w + 1 || k == TO) break;
        end
        exp_mem_valid = 1'b0;
        mem_ready     = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
    endtask

    always @(negedge clk) begin
        rsp_t e;
        chk("mem_valid", mem_valid, exp_mem_valid);
        if (mem_valid && exp_mem_valid) begin
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wstrb", mem_wstrb, exp_wstrb);
            chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=rsp_valid required=none cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_misalign", rsp_misalign, e.mis);
                chk("rsp_timeout", rsp_timeout, e.tmo);
                chk("rsp_cycle", cyc, e.at);
            end
        end else begin
            chk("rsp_idle_zero", rsp_rdata | {30'h0, rsp_misalign, rsp_timeout}, 32'h0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        rsp_t e;
        int   a, a2, r;
        bit   ok, imm;

        rst           = 1'b1;
        req_valid     = 1'b0;
        scramble();
        mem_ready     = 1'b0;
        mem_rdata     = 32'h0;
        exp_mem_valid = 1'b0;
        exp_we        = 1'b0;
        exp_addr      = 32'h0;
        exp_wstrb     = 4'h0;
        exp_wdata     = 32'h0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_req_ready", req_ready, 1'b0);
            chk("reset_mem_fields", mem_addr | mem_wdata | {27'h0, mem_we, mem_wstrb}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        txns.push_back('{we:1'b0, size:2'd0, uns:1'b0, addr:32'h1003, wdata:32'h0,        data:32'h80FF1234, w:0});
        txns.push_back('{we:1'b1, size:2'd1, uns:1'b0, addr:32'h2002, wdata:32'h0000ABCD, data:32'h0,        w:0});
        txns.push_back('{we:1'b0, size:2'd2, uns:1'b0, addr:32'h3001, wdata:32'h0,        data:32'h0,        w:0});
        txns.push_back('{we:1'b0, size:2'd2, uns:1'b0, addr:32'h4000, wdata:32'h0,        data:32'h0,        w:99});
        txns.push_back('{we:1'b0, size:2'd1, uns:1'b1, addr:32'h0010, wdata:32'h0,        data:32'h00008001, w:3});
        for (int i = 0; i < N_RAND; i++) txns.push_back(rand_txn());

        present(txns[0]);
        wait_accept(a, ok);
        for (int i = 0; i < txns.size() && ok; i++) begin
            t = txns[i];
            if (model_mis(t)) begin
                r = a;
                e = '{rdata:32'h0, mis:1'b1, tmo:1'b0, at:r};
            end else if (t.w + 1 <= TO) begin
                r = a + t.w + 1;
                e = '{rdata:(t.we ? 32'h0 : model_load(t)), mis:1'b0, tmo:1'b0, at:r};
            end else begin
                r = a + TO;
                e = '{rdata:32'h0, mis:1'b0, tmo:1'b1, at:r};
            end
            exp_q.push_back(e);

            imm = (i != txns.size() - 1) && ($urandom_range(0, 3) != 0);
            if (imm) begin
                present(txns[i+1]);
            end else begin
                req_valid = 1'b0;
                scramble();
            end
            bus_phase(t);
            if (i == txns.size() - 1) break;
            if (!imm) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                present(txns[i+1]);
            end
            wait_accept(a2, ok);
            if (ok && imm) chk("back_to_back_accept", a2, r + 2);
            a = a2;
        end
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("rsp_all_seen", exp_q.size(), 0);

        // Reset in the middle of a bus access abandons it without a completion.
        t = '{we:1'b0, size:2'd2, uns:1'b0, addr:32'h5000, wdata:32'h0, data:32'h0, w:99};
        present(t);
        wait_accept(a, ok);
        req_valid     = 1'b0;
        exp_we        = 1'b0;
        exp_addr      = 32'h5000;
        exp_wstrb     = 4'h0;
        exp_wdata     = 32'h0;
        exp_mem_valid = 1'b1;
        mem_ready     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_mem_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("no_rsp_after_rst", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of BUS-state cycles waited for mem_ready (legal range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: access request from execute stage.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1: load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr, input, 32: byte address, the ALU Result.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have ports mem_valid out 1, mem_ready in 1, mem_we out 1, mem_addr out 32, mem_wstrb out 4, mem_wdata out 32, mem_rdata in 32: data-memory bus.
REQ-012 SHALL have ports rsp_valid out 1, rsp_rdata out 32, rsp_misalign out 1, rsp_timeout out 1: completion report.

Function
REQ-013 SHALL implement FSM states IDLE, BUS, RESP; req_ready = 1 only in IDLE with rst low.
REQ-014 SHALL accept request on req_valid & req_ready; all request fields registered at that edge; inputs ignored otherwise.
REQ-015 SHALL flag misaligned: half with addr[0]=1, word with addr[1:0]!=00, or size 11; then IDLE->RESP directly, rsp_misalign=1, no bus cycle issued.
REQ-016 SHALL go IDLE->BUS for aligned requests; in BUS mem_valid=1 with mem_we, mem_addr, mem_wstrb, mem_wdata held stable until completion.
REQ-017 SHALL drive mem_addr = {addr[31:2],00}.
REQ-018 SHALL drive mem_wstrb for stores: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; 0000 for loads.
REQ-019 SHALL drive mem_wdata for stores: byte replicated x4, half replicated x2, word as-is; 0 for loads.
REQ-020 SHALL complete on a BUS cycle with mem_ready=1: load captures lane from mem_rdata at byte offset addr[1:0], extended to 32 bits per req_unsigned; store returns rsp_rdata=0; next state RESP.
REQ-021 SHALL count BUS cycles from 1; if mem_ready is still low on cycle TIMEOUT_CYCLES, drop mem_valid, go RESP with rsp_timeout=1, rsp_rdata=0.
REQ-022 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; rsp_rdata/flags valid only while rsp_valid=1, 0 otherwise.
REQ-023 SHALL give latency: accept edge N, BUS at N+1; if mem_ready=1 at N+1, rsp_valid at N+2; misaligned rsp_valid at N+1.
REQ-024 SHALL hold rsp_misalign and rsp_timeout mutually exclusive; mem_ready outside BUS ignored.

Reset
REQ-025 SHALL on rst=1 at an edge force IDLE, clear counter and captured data; outputs low after that edge: mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_misalign, rsp_timeout; req_ready=0 while rst=1.
REQ-026 SHALL on rst during BUS or RESP abandon the access: no rsp_valid emitted, mem_valid low from the next cycle.

Verification
REQ-027 Load byte addr 0x1003, signed, mem_rdata 0x80FF_1234, mem_ready at first BUS cycle -> mem_addr 0x1000, rsp_rdata 0xFFFF_FF80 two cycles after accept.
REQ-028 Store half addr 0x2002, wdata 0x0000_ABCD -> mem_wstrb 1100, mem_wdata 0xABCD_ABCD, mem_we=1, rsp_valid with rsp_rdata 0.
REQ-029 Load word addr 0x3001 -> no mem_valid ever, rsp_misalign=1 one cycle after accept, rsp_rdata 0.
REQ-030 Load word, mem_ready held 0, TIMEOUT_CYCLES=4 -> mem_valid high exactly 4 cycles, then rsp_timeout=1, rsp_rdata 0.
REQ-031 Load half addr 0x10, unsigned, mem_ready after 3 wait cycles, mem_rdata 0x0000_8001 -> rsp_rdata 0x0000_8001; req_ready=0 until rsp cycle done, back-to-back request accepted the cycle after rsp_valid.
REQ-032 rst pulsed during BUS -> mem_valid low next cycle, no rsp_valid, req_ready=1 first cycle after rst deasserts.
